cu_multicycle: RTL and testbench

- Parametrised multi-cycle successor to the combinational accumulator control unit.
- Sequences FETCH/DECODE/MEMORY/EXECUTE over a single shared memory port with a ready handshake.
- Latches the instruction register and drives the accumulator, ALU, PC and memory strobes.
- Adds zero-branch (BZ), a HALT state and a memory-wait watchdog.

---
 rtl/cu_multicycle.sv | 194 +++++++++++++++++++
 tb/tb_cu_multicycle.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cu_multicycle.sv
// Multi-cycle accumulator control unit: FETCH/DECODE/MEMORY/EXEC sequencing over one
// shared memory port, with zero-branch, HALT and a memory-wait watchdog.
//
// state  | meaning
// FETCH  | read instruction at PC, latch IR on mem_ready
// DECODE | one idle cycle to select the memory or execute path
// MEMRD  | operand read for ADD/LDA, accumulator written on mem_ready
// MEMWR  | accumulator store for STA, write strobe held until mem_ready
// EXEC   | single-cycle jumps, branches and LONG sub-ops
// HALT   | stopped by STOP or a watchdog trap, left only through rst
module cu_multicycle #(
   parameter int OP_W     = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     instr,
   input  logic                mem_ready,
   input  logic                acc_msb,
   input  logic                acc_zero,
   output logic                mem_req,
   output logic                addr_sel,
   output logic [OP_W-4:0]     operand,
   output logic                wmem,
   output logic                wacc,
   output logic [3:0]          alu_op,
   output logic [2:0]          pc_sel,
   output logic                halted,
   output logic                err
);

   localparam int OPND_W = OP_W - 3;
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   localparam logic [2:0] OPC_ADD  = 3'b000;
   localparam logic [2:0] OPC_STA  = 3'b001;
   localparam logic [2:0] OPC_LDA  = 3'b010;
   localparam logic [2:0] OPC_JMP  = 3'b011;
   localparam logic [2:0] OPC_BAN  = 3'b100;
   localparam logic [2:0] OPC_BZ   = 3'b101;
   localparam logic [2:0] OPC_LONG = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEMRD  = 3'd2,
      S_MEMWR  = 3'd3,
      S_EXEC   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [OP_W-1:0]   r_ir;
   logic [7:0]        r_wait;
   logic              r_err;

   logic [2:0]        w_opc;
   logic [OPND_W-1:0] w_opnd;
   logic              w_trap;
   logic              w_mem_req;
   logic              w_addr_sel;
   logic              w_wmem;
   logic              w_wacc;
   logic [3:0]        w_alu_op;
   logic [2:0]        w_pc_sel;
   logic              w_halted;
   logic              w_timeout;

   assign w_opc     = r_ir[OP_W-1:OP_W-3];
   assign w_opnd    = r_ir[OPND_W-1:0];
   assign w_timeout = !mem_ready && (r_wait == MAX_WAIT_C);

   always_comb begin
      w_next     = r_state;
      w_trap     = 1'b0;
      w_mem_req  = 1'b0;
      w_addr_sel = 1'b0;
      w_wmem     = 1'b0;
      w_wacc     = 1'b0;
      w_alu_op   = 4'd15;
      w_pc_sel   = 3'd0;
      w_halted   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_HALT;
               w_trap = 1'b1;
            end
         end
         S_DECODE: begin
            case (w_opc)
               OPC_ADD, OPC_LDA: w_next = S_MEMRD;
               OPC_STA:          w_next = S_MEMWR;
               default:          w_next = S_EXEC;
            endcase
         end
         S_MEMRD: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            if (mem_ready) begin
               w_wacc   = 1'b1;
               w_alu_op = (w_opc == OPC_ADD) ? 4'd1 : 4'd0;
               w_pc_sel = 3'd1;
               w_next   = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_HALT;
               w_trap = 1'b1;
            end
         end
         S_MEMWR: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_wmem     = 1'b1;
            if (mem_ready) begin
               w_pc_sel = 3'd1;
               w_next   = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_HALT;
               w_trap = 1'b1;
            end
         end
         S_EXEC: begin
            w_next = S_FETCH;
            case (w_opc)
               OPC_JMP: w_pc_sel = 3'd2;
               OPC_BAN: w_pc_sel = acc_msb  ? 3'd2 : 3'd1;
               OPC_BZ:  w_pc_sel = acc_zero ? 3'd2 : 3'd1;
               OPC_LONG: begin
                  // Sub-op field must be exactly one-hot; anything else degrades to NOP.
                  if (w_opnd == OPND_W'(5'b00001)) begin
                     w_wacc = 1'b1; w_alu_op = 4'd2; w_pc_sel = 3'd1;
                  end else if (w_opnd == OPND_W'(5'b00010)) begin
                     w_wacc = 1'b1; w_alu_op = 4'd3; w_pc_sel = 3'd1;
                  end else if (w_opnd == OPND_W'(5'b00100)) begin
                     w_wacc = 1'b1; w_alu_op = 4'd4; w_pc_sel = 3'd1;
                  end else if (w_opnd == OPND_W'(5'b01000)) begin
                     w_wacc = 1'b1; w_alu_op = 4'd5; w_pc_sel = 3'd1;
                  end else if (w_opnd == OPND_W'(5'b10000)) begin
                     w_next = S_HALT;
                  end else begin
                     w_pc_sel = 3'd1;
                  end
               end
               default: w_pc_sel = 3'd1;
            endcase
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_ir    <= '0;
         r_wait  <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && mem_ready) begin
            r_ir <= instr;
         end
         if (w_trap) begin
            r_err <= 1'b1;
         end
         // Every state change clears the wait count, so each memory state starts fresh.
         if (w_next != r_state) begin
            r_wait <= 8'd0;
         end else if (!mem_ready && (r_state == S_FETCH || r_state == S_MEMRD ||
                                     r_state == S_MEMWR)) begin
            r_wait <= r_wait + 8'd1;
         end
      end
   end

   assign mem_req  = rst ? 1'b0 : w_mem_req;
   assign addr_sel = rst ? 1'b0 : w_addr_sel;
   assign operand  = rst ? '0   : w_opnd;
   assign wmem     = rst ? 1'b0 : w_wmem;
   assign wacc     = rst ? 1'b0 : w_wacc;
   assign alu_op   = rst ? 4'd0 : w_alu_op;
   assign pc_sel   = rst ? 3'd0 : w_pc_sel;
   assign halted   = rst ? 1'b0 : w_halted;
   assign err      = rst ? 1'b0 : r_err;

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle: instruction sweep, memory waits, HALT, watchdog
// and reset behaviour, all against hand-computed strobe vectors.
module tb_cu_multicycle;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr;
   logic       mem_ready;
   logic       acc_msb;
   logic       acc_zero;
   logic       mem_req;
   logic       addr_sel;
   logic [4:0] operand;
   logic       wmem;
   logic       wacc;
   logic [3:0] alu_op;
   logic [2:0] pc_sel;
   logic       halted;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   cu_multicycle #(.OP_W(8), .MAX_WAIT(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .mem_ready (mem_ready),
      .acc_msb   (acc_msb),
      .acc_zero  (acc_zero),
      .mem_req   (mem_req),
      .addr_sel  (addr_sel),
      .operand   (operand),
      .wmem      (wmem),
      .wacc      (wacc),
      .alu_op    (alu_op),
      .pc_sel    (pc_sel),
      .halted    (halted),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Packed strobe vector: {mem_req, addr_sel, wmem, wacc, alu_op, pc_sel, halted, err}
   function automatic logic [12:0] vec(input logic mr, input logic as, input logic wm,
                                       input logic wa, input logic [3:0] alu,
                                       input logic [2:0] pc, input logic h, input logic e);
      return {mr, as, wm, wa, alu, pc, h, e};
   endfunction

   function automatic logic [12:0] outs();
      return {mem_req, addr_sel, wmem, wacc, alu_op, pc_sel, halted, err};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      check("rst_outs_zero", 32'(outs()), 32'(vec(0,0,0,0,4'd0,3'd0,0,0)));
      check("rst_operand", 32'(operand), 32'd0);
      rst = 1'b0;
      #1;
      check("fetch_after_rst", 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));
   endtask

   // Starts in FETCH just after an edge; zero-wait memory; ends back in FETCH.
   task automatic run_instr(input string tag, input logic [7:0] ins, input logic msb,
                            input logic zero, input logic [12:0] exp3,
                            input logic [4:0] exp_opnd);
      instr = ins; mem_ready = 1'b1; acc_msb = msb; acc_zero = zero;
      #1;
      check({tag, "_fetch"}, 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));
      tick();
      check({tag, "_decode"}, 32'(outs()), 32'(vec(0,0,0,0,4'd15,3'd0,0,0)));
      tick();
      check({tag, "_c3"}, 32'(outs()), 32'(exp3));
      check({tag, "_opnd"}, 32'(operand), 32'(exp_opnd));
      tick();
   endtask

   initial begin
      rst = 1'b1; instr = 8'h00; mem_ready = 1'b0; acc_msb = 1'b0; acc_zero = 1'b0;
      do_reset();

      run_instr("add",   8'h05, 0, 0, vec(1,1,0,1,4'd1,3'd1,0,0), 5'd5);
      run_instr("lda",   8'h45, 0, 0, vec(1,1,0,1,4'd0,3'd1,0,0), 5'd5);
      run_instr("jmp",   8'h6A, 0, 0, vec(0,0,0,0,4'd15,3'd2,0,0), 5'd10);
      run_instr("ban_t", 8'h87, 1, 0, vec(0,0,0,0,4'd15,3'd2,0,0), 5'd7);
      run_instr("ban_n", 8'h87, 0, 1, vec(0,0,0,0,4'd15,3'd1,0,0), 5'd7);
      run_instr("bz_n",  8'hA7, 1, 0, vec(0,0,0,0,4'd15,3'd1,0,0), 5'd7);
      run_instr("bz_t",  8'hA7, 0, 1, vec(0,0,0,0,4'd15,3'd2,0,0), 5'd7);
      run_instr("cla",   8'hE1, 0, 0, vec(0,0,0,1,4'd2,3'd1,0,0), 5'h01);
      run_instr("com",   8'hE2, 0, 0, vec(0,0,0,1,4'd3,3'd1,0,0), 5'h02);
      run_instr("shr",   8'hE4, 0, 0, vec(0,0,0,1,4'd4,3'd1,0,0), 5'h04);
      run_instr("csl",   8'hE8, 0, 0, vec(0,0,0,1,4'd5,3'd1,0,0), 5'h08);
      run_instr("ill_l", 8'hE3, 0, 0, vec(0,0,0,0,4'd15,3'd1,0,0), 5'h03);
      run_instr("ill_op",8'hC0, 0, 0, vec(0,0,0,0,4'd15,3'd1,0,0), 5'h00);

      // STA with two wait cycles in MEMWR
      instr = 8'h23; mem_ready = 1'b1;
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      check("sta_w1", 32'(outs()), 32'(vec(1,1,1,0,4'd15,3'd0,0,0)));
      check("sta_opnd", 32'(operand), 32'd3);
      tick();
      check("sta_w2", 32'(outs()), 32'(vec(1,1,1,0,4'd15,3'd0,0,0)));
      tick();
      mem_ready = 1'b1;
      #1;
      check("sta_rdy", 32'(outs()), 32'(vec(1,1,1,0,4'd15,3'd1,0,0)));
      tick();
      check("sta_done", 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));

      // STOP then HALT is immune to inputs
      run_instr("stop", 8'hF0, 0, 0, vec(0,0,0,0,4'd15,3'd0,0,0), 5'h10);
      for (int i = 0; i < 20; i++) begin
         instr = 8'(i * 37); mem_ready = i[0]; acc_msb = i[1]; acc_zero = i[2];
         #1;
         check("halt_hold", 32'(outs()), 32'(vec(0,0,0,0,4'd15,3'd0,1,0)));
         tick();
      end
      do_reset();

      // Watchdog trap in FETCH
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("wd_fetch", 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));
         tick();
      end
      check("wd_trap", 32'(outs()), 32'(vec(0,0,0,0,4'd15,3'd0,1,1)));
      tick();
      check("wd_sticky", 32'(outs()), 32'(vec(0,0,0,0,4'd15,3'd0,1,1)));
      do_reset();

      // Ready on the last permitted cycle completes normally
      mem_ready = 1'b0; instr = 8'h05;
      tick();
      tick();
      tick();
      mem_ready = 1'b1;
      #1;
      check("wd_edge_fetch", 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));
      tick();
      check("wd_edge_decode", 32'(outs()), 32'(vec(0,0,0,0,4'd15,3'd0,0,0)));
      tick();
      mem_ready = 1'b0;
      #1;
      check("memrd_wait", 32'(outs()), 32'(vec(1,1,0,0,4'd15,3'd0,0,0)));
      tick();
      rst = 1'b1;
      #1;
      check("rst_mid_wait", 32'(outs()), 32'(vec(0,0,0,0,4'd0,3'd0,0,0)));
      tick();
      rst = 1'b0;
      #1;
      check("fetch_after_wait_rst", 32'(outs()), 32'(vec(1,0,0,0,4'd15,3'd0,0,0)));
      check("ir_cleared", 32'(operand), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
